mem_port_arb: RTL
=================

// Module: mem_port_arb
// PURPOSE
//  Parametrised successor to the single-client memory controller of the RV32I core.
//  Arbitrates NCH request channels (ch0 = instruction fetch, ch1 = load/store, more for
//  future clients) onto the single 8-bit RAM/IO bus. Serialises 1/2/4-byte little-endian
//  reads and writes; supports per-channel cancel on branch flush and a pause via rdy_in.
// PARAMETERS
//  NCH     2   number of request channels, 1..8
//  ADDR_W  32  address width; mem_a carries the full value, RAM decodes [17:0]
//  DATA_W  32  maximum transfer width in bits (4 bytes)
// PORTS
//  clk_in      in   1          system clock
//  rst_in      in   1          synchronous, active-high reset
//  rdy_in      in   1          0 = freeze all state
//  req_valid   in   NCH        request pending, per channel
//  req_wr      in   NCH        1 = write, 0 = read
//  req_size    in   2*NCH      0 = 1 byte, 1 = 2 bytes, 2 = 4 bytes; 3 is illegal and treated as 4
//  req_addr    in   ADDR_W*NCH byte address of the first byte
//  req_wdata   in   DATA_W*NCH write data, byte 0 in [7:0]
//  req_cancel  in   NCH        abort the in-service read of this channel
//  req_ready   out  NCH        request accepted this cycle (one-hot or all zero)
//  resp_valid  out  NCH        one-cycle completion pulse
//  resp_rdata  out  DATA_W     read data, zero-extended; valid while resp_valid != 0
//  mem_din     in   8          RAM/IO read byte
//  mem_dout    out  8          RAM/IO write byte
//  mem_a       out  ADDR_W     RAM/IO address
//  mem_wr      out  1          1 = write
// BEHAVIOUR
//  - Reset values: FSM=IDLE; rr_ptr=0; all outputs 0. A reset mid-burst aborts the burst.
//    No resp_valid is issued for the aborted request.
//  - FSM states:
//    - IDLE: accept a request, go to RD or WR.
//    - RD, WR: next state is DONE after the last byte.
//    - DONE: pulse resp_valid, go to IDLE. DONE also accepts a new request (back-to-back).
//  - Arbitration: round-robin, starting at rr_ptr. After a grant to channel g, rr_ptr = g+1 mod NCH.
//    - req_ready[g] = (state IDLE or DONE) & req_valid[g] & granted & !req_cancel[g] & rdy_in.
//    - A request is latched on the edge where req_ready[g]=1.
//    - The channel holds req_* stable until req_ready.
//  - Read of N bytes, accepted at edge T:
//    - mem_a = addr+k, mem_wr=0 in cycle T+1+k, for k=0..N-1.
//    - mem_din for byte k is sampled at the end of cycle T+2+k.
//    - resp_valid and resp_rdata in cycle T+N+2. 4-byte read latency = 6.
//  - Write of N bytes: mem_a = addr+k, mem_dout = byte k, mem_wr=1 in cycle T+1+k.
//    resp_valid in cycle T+N+1 (1-byte write: 2 cycles).
//  - Bus when idle: mem_a=0, mem_dout=0, mem_wr=0.
//  - Address arithmetic is modulo 2^ADDR_W; no alignment checks.
//  - IO region is addr[17:16]==2'b11. IO reads are never cancelled; the burst completes and
//    resp_valid is still pulsed.
//  - Cancel:
//    - req_cancel[i] during a RAM read of channel i: no further bytes are issued and the FSM
//      goes to IDLE at the next edge. No resp_valid is issued.
//    - Cancel during a write, or for a channel not in service, is ignored.
//  - rdy_in=0: FSM, counters, rr_ptr, mem_a and mem_dout hold. mem_wr is forced to 0
//    (combinationally gated). resp_valid is forced to 0 and re-presented on resume.
//    An in-flight read byte is captured on the first rdy_in=1 cycle after its issue cycle.
//  - Simultaneous cancel and resp_valid in DONE: the response is delivered and cancel is ignored.
// STRUCTURE
//  - mem_port_pkg: size encodings, FSM state enum, IO_MASK/IO_VAL constants, size_to_bytes function.
//  - Sub-module rr_arbiter #(NCH): req vector + ptr -> one-hot grant.
//  - Top-level parts: FSM, byte counter, 32-bit shift/assemble register.
// TESTING
//  1. ch1 4-byte read at 0x100, RAM[0x100..0x103]=11,22,33,44 -> mem_a 0x100..0x103 in cycles T+1..T+4;
//     resp_valid[1] at T+6; rdata = 0x44332211.
//  2. ch1 2-byte write 0xBEEF at 0x200 -> mem_wr=1 with EF@0x200 then BE@0x201; resp_valid at T+3.
//  3. ch0 and ch1 valid every cycle -> grants alternate 0,1,0,1; no idle cycle between bursts.
//  4. ch0 4-byte read, req_cancel[0] at T+2 -> no mem_a change after T+2, no resp_valid[0];
//     a ch1 request is accepted at T+3.
//  5. ch1 1-byte read at 0x30000 with cancel at T+1 -> the read completes; resp_valid[1] at T+3.
//  6. rdy_in low for 3 cycles mid-write at byte 1 -> mem_wr=0 while low; byte 1 written exactly once;
//     resp is delayed 3 cycles. Also: rst_in mid-read -> all outputs 0 next cycle, no resp.

Source files
------------

// File: rtl/mem_port_pkg.sv
// Shared types and constants for the multi-channel memory port arbiter.
// Covers size encodings, FSM states, IO region decode and byte counts.
package mem_port_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2,
    SZ_RSVD = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [17:0] IO_MASK = 18'h30000;
  localparam logic [17:0] IO_VAL  = 18'h30000;

  // The reserved encoding behaves as a full word.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    case (size_e'(size))
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_io(input logic [17:0] addr);
    return (addr & IO_MASK) == IO_VAL;
  endfunction

endpackage

// File: rtl/mem_port_arb_rr_arbiter.sv
// Round-robin arbiter: one-hot grant to the first requester at or after ptr.
// Walking from the farthest slot down lets the nearest requester win.
module rr_arbiter #(
  parameter int NCH   = 2,
  parameter int PTR_W = 1
) (
  input  logic [NCH-1:0]   req,
  input  logic [PTR_W-1:0] ptr,
  output logic [NCH-1:0]   grant,
  output logic [PTR_W-1:0] grant_idx
);

  logic [PTR_W-1:0] idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      idx = PTR_W'((int'(ptr) + i) % NCH);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/mem_port_arb.sv
// Arbitrates NCH request channels onto the 8-bit RAM/IO bus, serialising
// 1/2/4-byte little-endian transfers with cancel and rdy_in pause support.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | bus idle, accept a granted request
//   ST_RD   | issue read bytes, then capture the last returning byte
//   ST_WR   | issue write bytes, one per cycle
//   ST_DONE | pulse resp_valid; may accept the next request directly
module mem_port_arb
  import mem_port_pkg::*;
#(
  parameter int NCH    = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [NCH-1:0]        req_valid,
  input  logic [NCH-1:0]        req_wr,
  input  logic [2*NCH-1:0]      req_size,
  input  logic [ADDR_W*NCH-1:0] req_addr,
  input  logic [DATA_W*NCH-1:0] req_wdata,
  input  logic [NCH-1:0]        req_cancel,
  output logic [NCH-1:0]        req_ready,
  output logic [NCH-1:0]        resp_valid,
  output logic [DATA_W-1:0]     resp_rdata,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_W-1:0]     mem_a,
  output logic                  mem_wr
);

  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_e              state_q, state_nxt;
  logic [PTR_W-1:0]    rr_ptr, ch_q, gnt_idx;
  logic [NCH-1:0]      gnt, ch_onehot;
  logic [ADDR_W-1:0]   addr_arr  [NCH];
  logic [DATA_W-1:0]   wdata_arr [NCH];
  logic [1:0]          size_arr  [NCH];
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [1:0]          sel_size;
  logic                sel_wr;
  logic [ADDR_W-1:0]   addr_q, mem_a_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [7:0]          mem_dout_q;
  logic                mem_wr_q;
  logic [1:0]          left_q, rd_idx_q;
  logic                issue_q, rd_pend_q, io_q;
  logic                start, abort;

  always_comb begin
    for (int i = 0; i < NCH; i++) begin
      addr_arr[i]  = req_addr[i*ADDR_W +: ADDR_W];
      wdata_arr[i] = req_wdata[i*DATA_W +: DATA_W];
      size_arr[i]  = req_size[i*2 +: 2];
    end
  end

  rr_arbiter #(.NCH(NCH), .PTR_W(PTR_W)) u_arb (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .grant     (gnt),
    .grant_idx (gnt_idx)
  );

  assign sel_addr  = addr_arr[gnt_idx];
  assign sel_wdata = wdata_arr[gnt_idx];
  assign sel_size  = size_arr[gnt_idx];
  assign sel_wr    = req_wr[gnt_idx];
  assign ch_onehot = NCH'(1) << ch_q;

  always_comb begin
    state_nxt  = state_q;
    req_ready  = '0;
    resp_valid = '0;
    start      = 1'b0;
    abort      = 1'b0;
    if (rdy_in) begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (state_q == ST_DONE) resp_valid = ch_onehot;
          req_ready = gnt & req_valid & ~req_cancel;
          if (|req_ready) begin
            start     = 1'b1;
            state_nxt = sel_wr ? ST_WR : ST_RD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
        ST_RD: begin
          // IO reads have side effects, so they always run to completion.
          if (req_cancel[ch_q] && !io_q) begin
            abort     = 1'b1;
            state_nxt = ST_IDLE;
          end else if (rd_pend_q && !issue_q) begin
            state_nxt = ST_DONE;
          end
        end
        ST_WR: begin
          if (left_q == 2'd0) state_nxt = ST_DONE;
        end
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_nxt;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      rr_ptr     <= '0;
      ch_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      mem_a_q    <= '0;
      mem_dout_q <= '0;
      mem_wr_q   <= 1'b0;
      left_q     <= '0;
      rd_idx_q   <= '0;
      issue_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
      io_q       <= 1'b0;
    end else if (rdy_in) begin
      if (start) begin
        rr_ptr     <= PTR_W'((int'(gnt_idx) + 1) % NCH);
        ch_q       <= gnt_idx;
        mem_a_q    <= sel_addr;
        mem_dout_q <= sel_wdata[7:0];
        mem_wr_q   <= sel_wr;
        addr_q     <= sel_addr + 1'b1;
        wdata_q    <= sel_wdata >> 8;
        left_q     <= 2'(size_to_bytes(sel_size) - 3'd1);
        rd_idx_q   <= '0;
        rdata_q    <= '0;
        issue_q    <= 1'b1;
        rd_pend_q  <= 1'b0;
        io_q       <= is_io(sel_addr[17:0]);
      end else begin
        case (state_q)
          ST_RD: begin
            if (abort) begin
              mem_a_q   <= '0;
              issue_q   <= 1'b0;
              rd_pend_q <= 1'b0;
            end else begin
              // Bytes return one cycle after issue; rd_pend_q marks one in flight.
              rd_pend_q <= issue_q;
              if (rd_pend_q) begin
                rdata_q[{rd_idx_q, 3'b000} +: 8] <= mem_din;
                rd_idx_q <= rd_idx_q + 2'd1;
              end
              if (issue_q) begin
                if (left_q != 2'd0) begin
                  mem_a_q <= addr_q;
                  addr_q  <= addr_q + 1'b1;
                  left_q  <= left_q - 2'd1;
                end else begin
                  issue_q <= 1'b0;
                end
              end
              if (rd_pend_q && !issue_q) mem_a_q <= '0;
            end
          end
          ST_WR: begin
            if (left_q == 2'd0) begin
              mem_a_q    <= '0;
              mem_dout_q <= '0;
              mem_wr_q   <= 1'b0;
            end else begin
              mem_a_q    <= addr_q;
              addr_q     <= addr_q + 1'b1;
              mem_dout_q <= wdata_q[7:0];
              wdata_q    <= wdata_q >> 8;
              left_q     <= left_q - 2'd1;
            end
          end
          default: begin
            mem_a_q    <= '0;
            mem_dout_q <= '0;
            mem_wr_q   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign mem_a      = mem_a_q;
  assign mem_dout   = mem_dout_q;
  assign mem_wr     = mem_wr_q & rdy_in;
  assign resp_rdata = rdata_q;

endmodule
